// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the divided-clock duty/period checker.
// Expected period/high time are derived from the divide ratio.
package clk_div_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } arm_state_e;

  typedef struct packed {
    logic period;
    logic duty;
    logic stuck;
  } err_flags_t;

  // Expected period of a 50%-duty divide-by-div clock, in half-cycles.
  function automatic int unsigned exp_period(input int unsigned div);
    return 2 * div;
  endfunction

  // Expected high time, in half-cycles.
  function automatic int unsigned exp_high(input int unsigned div);
    return div;
  endfunction

endpackage

// File: rtl/clk_div_dual_edge_sampler.sv
// Samples div_in on both clk edges and presents one ordered half-sample pair
// per clk cycle, plus rising-edge detection within that pair.
module clk_div_dual_edge_sampler
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic div_in,
  output logic h0,
  output logic h1,
  output logic rise,
  output logic rise_pos
);

  logic s_neg;
  logic s_pos;
  logic h0_q;
  logic prev;

  always_ff @(negedge clk) begin
    if (reset) begin
      s_neg <= 1'b0;
    end else begin
      s_neg <= div_in;
    end
  end

  // h0 is re-registered here so the pair stays ordered after the next negedge.
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q  <= 1'b0;
      s_pos <= 1'b0;
      prev  <= 1'b0;
    end else begin
      h0_q  <= s_neg;
      s_pos <= div_in;
      prev  <= s_pos;
    end
  end

  assign h0       = h0_q;
  assign h1       = s_pos;
  assign rise     = (~prev & h0_q) | (~h0_q & s_pos);
  // 1: edge falls on h1; 0: edge on h0 (only meaningful when rise is set).
  assign rise_pos = ~h0_q & s_pos;

endmodule

// File: rtl/clk_div_duty_checker.sv
// Measures period and high time of a dual-edge divided clock in half-cycles,
// flags period/duty/stuck errors and tracks lock over consecutive good periods.
module clk_div_duty_checker
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV      = 3,
  parameter int unsigned CW       = 8,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          div_in,
  output logic          meas_valid,
  output logic [CW-1:0] meas_period,
  output logic [CW-1:0] meas_high,
  output logic          period_err,
  output logic          duty_err,
  output logic          stuck_err,
  output logic          locked
);

  localparam int unsigned EXP_PERIOD = exp_period(DIV);
  localparam int unsigned EXP_HIGH   = exp_high(DIV);
  localparam int unsigned GW         = $clog2(LOCK_CNT + 1);

  localparam logic [CW-1:0] EXP_PERIOD_C = CW'(EXP_PERIOD);
  localparam logic [CW-1:0] EXP_HIGH_C   = CW'(EXP_HIGH);
  localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [GW-1:0] LOCK_C       = GW'(LOCK_CNT);

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW - 1){1'b0}}, b};
    return s[CW] ? CNT_MAX : s[CW-1:0];
  endfunction

  logic h0, h1, rise, rise_pos;

  clk_div_dual_edge_sampler u_sampler (
    .clk      (clk),
    .reset    (reset),
    .div_in   (div_in),
    .h0       (h0),
    .h1       (h1),
    .rise     (rise),
    .rise_pos (rise_pos)
  );

  arm_state_e    state_q, state_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [GW-1:0] good_q, good_d;
  logic          mv_q, mv_d;
  logic [CW-1:0] mp_q, mp_d;
  logic [CW-1:0] mh_q, mh_d;
  err_flags_t    err_q, err_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] cand_period, cand_high;
  logic [1:0]    ones_pair;

  assign ones_pair = {1'b0, h0} + {1'b0, h1};

  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    hi_d        = hi_q;
    good_d      = good_q;
    mv_d        = 1'b0;
    mp_d        = mp_q;
    mh_d        = mh_q;
    err_d       = '0;
    cand_period = per_q;
    cand_high   = hi_q;

    if (!en) begin
      state_d = IDLE;
    end else if (rise) begin
      // Samples before the edge in this pair close the old period; the rest open the new one.
      if (rise_pos) begin
        cand_period = sat_add(per_q, 2'd1);
        cand_high   = hi_q;
        per_d       = CW'(1);
        hi_d        = CW'(1);
      end else begin
        cand_period = per_q;
        cand_high   = hi_q;
        per_d       = CW'(2);
        hi_d        = h1 ? CW'(2) : CW'(1);
      end
      if (state_q == ARMED) begin
        mv_d         = 1'b1;
        mp_d         = cand_period;
        mh_d         = cand_high;
        err_d.period = (cand_period != EXP_PERIOD_C);
        err_d.duty   = (cand_high != EXP_HIGH_C);
      end
      state_d = ARMED;
    end else begin
      per_d = sat_add(per_q, 2'd2);
      hi_d  = sat_add(hi_q, ones_pair);
      if (state_q == ARMED && per_d >= TIMEOUT_C) begin
        err_d.stuck = 1'b1;
        state_d     = IDLE;
      end
    end

    if (|err_d) begin
      good_d = '0;
    end else if (mv_d && good_q != LOCK_C) begin
      good_d = good_q + GW'(1);
    end
    locked_d = (good_d == LOCK_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      good_q   <= '0;
      mv_q     <= 1'b0;
      mp_q     <= '0;
      mh_q     <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      good_q   <= good_d;
      mv_q     <= mv_d;
      mp_q     <= mp_d;
      mh_q     <= mh_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign meas_valid  = mv_q;
  assign meas_period = mp_q;
  assign meas_high   = mh_q;
  assign period_err  = err_q.period;
  assign duty_err    = err_q.duty;
  assign stuck_err   = err_q.stuck;
  assign locked      = locked_q;

endmodule

// File: doc/clk_div_duty_checker.md
Name: clk_div_duty_checker

Overview:
- Downstream monitor for the 50%-duty odd/even clock dividers. It consumes a divided clock (div_in) that was generated from clk and toggles on both clk edges.
- Measures the period and high time of div_in at half-cycle resolution and compares them against the expected divide ratio.
- Reports per-period measurements, error pulses and a lock indication to the clock-management status logic.

Parameters:
- DIV, 3, expected divide ratio. Expected period is 2*DIV half-cycles; expected high time is DIV half-cycles.
- CW, 8, width of the measurement counters and outputs.
- TIMEOUT, 64, number of half-samples with no rising edge before stuck_err fires.
- LOCK_CNT, 4, number of consecutive good periods required to assert locked.

Ports:
- clk  in  1  reference clock; the source of div_in.
- reset  in  1  sync reset, active-high.
- en  in  1  checker enable.
- div_in  in  1  divided clock under test, treated as data.
- meas_valid  out  1  one-cycle pulse; a measurement is presented.
- meas_period  out  CW  measured period in half-cycles.
- meas_high  out  CW  measured high time in half-cycles.
- period_err  out  1  pulse with meas_valid when meas_period != 2*DIV.
- duty_err  out  1  pulse with meas_valid when meas_high != DIV.
- stuck_err  out  1  one-cycle pulse on timeout.
- locked  out  1  level; LOCK_CNT consecutive good periods seen.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk. reset is also sampled on negedge clk, where it clears the negedge capture register.
- Sampling:
  - div_in is captured at negedge clk into s_neg and at posedge clk into s_pos.
  - Each posedge consumes one ordered pair (h0 = s_neg from the preceding negedge, h1 = current posedge sample).
  - prev holds h1 of the previous pair.
- Rising edge in the stream: prev=0,h0=1, or h0=0,h1=1. At most one rising edge can occur per pair. The edge position (0 or 1) selects how the counters split.
- Counters:
  - per_cnt counts half-samples since the last rise; hi_cnt counts 1-samples since the last rise.
  - Both saturate at 2^CW-1 and never wrap.
  - On a rise, counting restarts from the half-sample at the edge: an edge at h0 restarts with 2 samples, an edge at h1 with 1.
- Arm state machine:
  - States: IDLE, ARMED.
  - IDLE -> ARMED on the first rise after reset, after en going high, or after a timeout. No measurement is produced on that arming rise.
  - In ARMED, each rise completes one measurement.
- Output latency:
  - Outputs are registered. meas_valid, meas_period, meas_high, period_err and duty_err update at the posedge following the posedge that consumed the rise.
  - meas_period/meas_high hold their value until the next meas_valid.
- Timeout:
  - When per_cnt reaches TIMEOUT with no rise, stuck_err pulses for 1 cycle, the state machine returns to IDLE and the lock is cleared.
  - stuck_err then stays quiet until the next rise re-arms.
- Lock:
  - good_cnt increments on each meas_valid with no error and saturates at LOCK_CNT. locked = (good_cnt == LOCK_CNT).
  - Any period_err, duty_err or stuck_err clears good_cnt and deasserts locked in the same cycle as the error.
- Enable: en=0 holds all counters, forces IDLE and suppresses all pulses. locked holds its value. Re-enable requires a fresh arming rise.
- Reset values: all outputs 0; counters 0; prev=0; s_neg=0; state IDLE.
- Reset mid-operation discards any partial measurement and emits no pulse in the reset cycle.

Decomposition:
- Shared package clk_div_pkg:
  - localparam EXP_PERIOD = 2*DIV and EXP_HIGH = DIV, as functions of DIV.
  - Arm-state enum (IDLE, ARMED).
  - Error-flags struct {period, duty, stuck}.
- Sub-module clk_div_dual_edge_sampler:
  - Contains the negedge/posedge capture and prev register.
  - Outputs the ordered pair h0/h1 plus rise and rise_pos.
- Measurement, timeout and lock logic stays in the top module.

Test Plan:
- DIV=3, ideal waveform (3 half-cycles high, 3 low), en=1 -> first rise arms only. meas_valid then pulses every 3 clk cycles with period=6, high=3 and no errors. locked=1 at the 4th good measurement.
- DIV=3, waveform 4 high / 2 low -> meas_valid with period=6, high=4; duty_err=1, period_err=0; locked=0.
- DIV=3, waveform 4 high / 4 low after lock -> period=8, high=4; period_err=1 and duty_err=1; locked drops in the same cycle as the errors.
- div_in held 0 after arming -> stuck_err pulses once after 64 half-samples (32 cycles), then no further pulses. The next rise re-arms without producing a measurement.
- DIV=1, div_in = clk-rate toggle (pattern 1,0 per pair) -> period=2, high=1 every cycle; locked after 4 cycles.
- Reset asserted mid-period, then released -> all outputs 0 in the reset cycle. The first post-reset rise only arms; measurements resume correctly afterwards.
